// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch slice.
// Contents: RV32 major-opcode constants and a small opcode extraction helper.
// Optional feature macro used by this slice: FETCH_BTFN_EN (see next_pc_gen).
package inst_fetcher_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  // Major opcode field of an RV32 instruction word.
  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/inst_fetcher_next_pc_gen.sv
// next_pc_gen: static next-PC prediction for one fetched instruction.
// Ports:
//   word    in  32      fetched instruction word
//   pc      in  ADDR_W  PC of that word
//   next_pc out ADDR_W  predicted next PC (wraps modulo 2^ADDR_W)
//   pred    out 1       predicted-taken flag
// JAL is always followed. With FETCH_BTFN_EN defined, backward conditional
// branches (immB sign bit set) are predicted taken; otherwise all branches
// fall through to pc+4. JALR and mispredictions are left to the ROB redirect.
module next_pc_gen
  import inst_fetcher_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [31:0]       word,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pred
);

  logic [ADDR_W-1:0] imm_j;
  logic [ADDR_W-1:0] pc_plus4;

  // immJ = {imm[20], imm[10:1], imm[11], imm[19:12]} scattered in the word
  assign imm_j    = {{(ADDR_W-20){word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
  assign pc_plus4 = pc + {{(ADDR_W-3){1'b0}}, 3'd4};

`ifdef FETCH_BTFN_EN
  logic [ADDR_W-1:0] imm_b;
  assign imm_b = {{(ADDR_W-12){word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
`else
  // immB fields only matter when backward branches are predicted
  logic unused_imm_b_bits;
  assign unused_imm_b_bits = ^word[11:7];
`endif

  // Opcode-directed next-PC selection
  always_comb begin
    next_pc = pc_plus4;
    pred    = 1'b0;
    case (opcode_of(word))
      OP_JAL: begin
        next_pc = pc + imm_j;
        pred    = 1'b1;
      end
`ifdef FETCH_BTFN_EN
      OP_BRANCH: begin
        if (word[31]) begin
          next_pc = pc + imm_b;
          pred    = 1'b1;
        end else begin
          next_pc = pc_plus4;
          pred    = 1'b0;
        end
      end
`endif
      default: begin
        next_pc = pc_plus4;
        pred    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch stage in front of the issue queue.
// Holds the PC, issues one instruction-cache read at a time and delivers
// {word, pc, prediction} to the issue queue one cycle after the response.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low = freeze)
//   _clear/_new_pc        ROB redirect
//   _need_inst            issue queue has room
//   _icache_req/_icache_addr, _icache_valid/_icache_data   cache handshake
//   _inst_ready_out/_inst_out/_inst_addr_out/_inst_pred_out  to issue queue
// Optional macro: FETCH_BTFN_EN (backward-taken branch prediction, in next_pc_gen).
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              _clear,
  input  logic [ADDR_W-1:0] _new_pc,
  input  logic              _need_inst,
  output logic              _icache_req,
  output logic [ADDR_W-1:0] _icache_addr,
  input  logic              _icache_valid,
  input  logic [31:0]       _icache_data,
  output logic              _inst_ready_out,
  output logic [31:0]       _inst_out,
  output logic [ADDR_W-1:0] _inst_addr_out,
  output logic              _inst_pred_out
);

  // DROP: a request is in flight but a redirect made its answer stale
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic              ready_r;
  logic [31:0]       inst_r;
  logic [ADDR_W-1:0] inst_addr_r;
  logic              pred_r;

  logic [ADDR_W-1:0] npc_s;
  logic              pred_s;

  next_pc_gen #(.ADDR_W(ADDR_W)) u_next_pc_gen (
    .word    (_icache_data),
    .pc      (pc_r),
    .next_pc (npc_s),
    .pred    (pred_s)
  );

  // Fetch FSM with PC and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC;
      req_r       <= 1'b0;
      addr_r      <= '0;
      ready_r     <= 1'b0;
      inst_r      <= 32'h0000_0000;
      inst_addr_r <= '0;
      pred_r      <= 1'b0;
    end else if (rdy_in) begin
      req_r   <= 1'b0;
      ready_r <= 1'b0;
      if (_clear) begin
        pc_r <= _new_pc;
        case (state_r)
          S_IDLE:         state_r <= S_IDLE;
          // a response arriving with the clear closes the transaction
          S_WAIT, S_DROP: state_r <= _icache_valid ? S_IDLE : S_DROP;
          default:        state_r <= S_IDLE;
        endcase
      end else begin
        case (state_r)
          S_IDLE: begin
            if (_need_inst) begin
              req_r   <= 1'b1;
              addr_r  <= {pc_r[ADDR_W-1:2], 2'b00};
              state_r <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (_icache_valid) begin
              inst_r      <= _icache_data;
              inst_addr_r <= pc_r;
              pred_r      <= pred_s;
              ready_r     <= 1'b1;
              pc_r        <= npc_s;
              state_r     <= S_IDLE;
            end
          end
          S_DROP: begin
            if (_icache_valid) begin
              state_r <= S_IDLE;
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  // Pulses are masked while frozen so a held register reappears exactly once
  // when the pipeline resumes, matching the rdy-gated memory controller.
  assign _icache_req    = req_r & rdy_in;
  assign _inst_ready_out = ready_r & rdy_in;
  assign _icache_addr   = addr_r;
  assign _inst_out      = inst_r;
  assign _inst_addr_out = inst_addr_r;
  assign _inst_pred_out = pred_r;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed steps followed by a
// randomized sequence, checked against an arithmetic next-PC model.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic        need = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        valid = 1'b0;
  logic [31:0] data = 32'h0;
  logic        iready;
  logic [31:0] iword;
  logic [31:0] iaddr;
  logic        ipred;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_pc;

  inst_fetcher #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), ._clear(clr), ._new_pc(new_pc),
    ._need_inst(need), ._icache_req(req), ._icache_addr(addr),
    ._icache_valid(valid), ._icache_data(data), ._inst_ready_out(iready),
    ._inst_out(iword), ._inst_addr_out(iaddr), ._inst_pred_out(ipred)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V immediate decoding done with plain integer arithmetic.
  function automatic void ref_next(input logic [31:0] pc, input logic [31:0] w,
                                   output logic [31:0] npc, output logic pred);
    longint off;
    npc  = pc + 32'd4;
    pred = 1'b0;
    if ((w & 32'h7f) == 32'h6f) begin
      off = longint'((w >> 21) & 32'h3ff) * 2 + longint'((w >> 20) & 32'h1) * 2048
          + longint'((w >> 12) & 32'hff) * 4096;
      if (w[31]) off = off - 1048576;
      npc  = 32'(longint'(pc) + off);
      pred = 1'b1;
    end
`ifdef FETCH_BTFN_EN
    else if ((w & 32'h7f) == 32'h63 && w[31]) begin
      off = longint'((w >> 8) & 32'hf) * 2 + longint'((w >> 25) & 32'h3f) * 32
          + longint'((w >> 7) & 32'h1) * 2048 - 4096;
      npc  = 32'(longint'(pc) + off);
      pred = 1'b1;
    end
`endif
  endfunction

  // Wait (bounded) for a request and check its address; ready must stay low meanwhile.
  task automatic expect_req(input logic [31:0] exp_addr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (!req) chk("no_ready_before_req", {31'd0, iready}, 32'd0);
    end while (!req && n < 20);
    chk("req_seen", {31'd0, req}, 32'd1);
    chk("req_addr", addr, exp_addr);
  endtask

  // Answer the outstanding request after lat cycles and check the delivery.
  task automatic respond(input logic [31:0] w, input int lat);
    logic [31:0] npc;
    logic        pr;
    for (int i = 0; i < lat - 1; i++) begin
      tick();
      chk("wait_no_ready", {31'd0, iready}, 32'd0);
      chk("wait_no_req", {31'd0, req}, 32'd0);
    end
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
    ref_next(m_pc, w, npc, pr);
    chk("inst_ready", {31'd0, iready}, 32'd1);
    chk("inst_word", iword, w);
    chk("inst_addr", iaddr, m_pc);
    chk("inst_pred", {31'd0, ipred}, {31'd0, pr});
    m_pc = npc;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"}, {31'd0, req}, 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_ready"}, {31'd0, iready}, 32'd0);
    chk({tag, "_word"}, iword, 32'd0);
    chk({tag, "_iaddr"}, iaddr, 32'd0);
    chk({tag, "_pred"}, {31'd0, ipred}, 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0: return {r[31:7], 7'h33};
      1: return {r[31:7], 7'h6f};
      2: return {r[31:7], 7'h63};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] r;
    int lat;
    int mode;
    bit simul;

    // 1: reset overrides _clear and rdy_in; outputs all zero
    rst = 1'b0; clr = 1'b1; new_pc = 32'h0000_0500; need = 1'b1; rdy = 1'b0;
    tick(); chk_outputs_zero("reset1");
    tick(); chk_outputs_zero("reset2");
    rst = 1'b1; clr = 1'b0; rdy = 1'b1;
    m_pc = 32'h0;
    expect_req(32'h0);

    // 2: sequential fetch, latency 3
    respond(32'h0000_0013, 3);
    expect_req(32'h4);
    respond(32'h0000_0013, 1);
    expect_req(32'h8);
    respond(32'h0000_0013, 2);
    expect_req(32'hC);
    respond(32'h0000_0013, 1);

    // 3: JAL +16 at 0x10
    expect_req(32'h10);
    respond(32'h0100_006F, 2);
    chk("jal_pred", {31'd0, ipred}, 32'd1);
    expect_req(32'h20);

    // 4a: flush in WAIT, stale response one cycle later
    clr = 1'b1; new_pc = 32'h100;
    tick();
    clr = 1'b0; valid = 1'b1; data = 32'h0000_006F;
    tick();
    valid = 1'b0;
    chk("drop_no_ready", {31'd0, iready}, 32'd0);
    m_pc = 32'h100;
    expect_req(32'h100);

    // 4b: flush coincident with the response
    tick();
    clr = 1'b1; new_pc = 32'h0; valid = 1'b1; data = 32'h0100_006F;
    tick();
    clr = 1'b0; valid = 1'b0;
    chk("simul_no_ready", {31'd0, iready}, 32'd0);
    m_pc = 32'h0;
    expect_req(32'h0);

    // 3b: JAL -4 at 0 wraps
    respond(32'hFFDF_F06F, 2);
    expect_req(32'hFFFF_FFFC);
    respond(32'h0000_0013, 1);
    chk("wrap_next", m_pc, 32'h0);

    // 5a: no request while the issue queue is full
    need = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("need0_no_req", {31'd0, req}, 32'd0);
    end
    need = 1'b1;
    expect_req(32'h0);

    // 5b: freeze mid-WAIT; clear and valid are ignored while frozen
    tick();
    rdy = 1'b0; clr = 1'b1; new_pc = 32'h500; valid = 1'b1; data = 32'h0100_006F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frozen_no_req", {31'd0, req}, 32'd0);
      chk("frozen_no_ready", {31'd0, iready}, 32'd0);
    end
    rdy = 1'b1; clr = 1'b0; valid = 1'b0;
    respond(32'h0000_0013, 2);
    chk("resume_addr", iaddr, 32'h0);

    // clear in the delivery cycle: pulse already out, no request this cycle
    clr = 1'b1; new_pc = 32'h40;
    tick();
    clr = 1'b0;
    chk("clear_idle_no_req", {31'd0, req}, 32'd0);
    m_pc = 32'h40;
    expect_req(32'h40);

    // 6: beq -4 at 0x40
    respond(32'hFE00_0EE3, 2);
`ifdef FETCH_BTFN_EN
    chk("btfn_pred", {31'd0, ipred}, 32'd1);
    expect_req(32'h3C);
`else
    chk("btfn_pred", {31'd0, ipred}, 32'd0);
    expect_req(32'h44);
`endif

    // Randomized traffic: request already seen at the top of each iteration
    for (int it = 0; it < 60; it++) begin
      w    = rand_word();
      lat  = $urandom_range(1, 5);
      mode = $urandom_range(0, 5);
      if (mode == 0) begin
        tick();
        r = $urandom();
        new_pc = {r[31:2], 2'b00};
        simul  = ($urandom_range(0, 1) == 1);
        clr = 1'b1; valid = simul; data = w;
        tick();
        clr = 1'b0;
        if (!simul) begin
          valid = 1'b1;
          tick();
        end
        valid = 1'b0;
        chk("rand_flush_no_ready", {31'd0, iready}, 32'd0);
        m_pc = new_pc;
      end else if (mode == 1) begin
        tick();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("rand_frozen_req", {31'd0, req}, 32'd0);
        end
        rdy = 1'b1;
        respond(w, lat);
      end else begin
        respond(w, lat);
        if (mode == 2) begin
          need = 1'b0;
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            tick();
            chk("rand_need0_req", {31'd0, req}, 32'd0);
          end
          need = 1'b1;
        end
      end
      expect_req({m_pc[31:2], 2'b00});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
